// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared definitions for the machine-mode trap controller.
//   - FSM state encoding
//   - default mcause values for the traps this controller raises
//   - mtvec mode field encodings
// Optional feature macro: TRAP_VECTORED_MTVEC_EN (see trap_target_calc).
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_JUMP = 2'd2,
    ST_RET  = 2'd3
  } state_e;

  localparam logic [31:0] DEF_CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] DEF_CAUSE_MTIMER  = 32'h8000_0007;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_ctrl_target_calc.sv
// trap_target_calc: combinational redirect-PC mux.
//   sel_mepc_i  1     select mepc (mret return) instead of the trap vector
//   mtvec_i     XLEN  current mtvec (base + mode)
//   mepc_i      XLEN  current mepc
//   cause_i     XLEN  latched mcause (only with TRAP_VECTORED_MTVEC_EN)
//   target_o    XLEN  redirect PC
// Macro TRAP_VECTORED_MTVEC_EN: when defined, interrupts with mtvec mode
// 2'b01 vector to base + 4*cause; otherwise direct mode is always used.
module trap_target_calc
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            sel_mepc_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
`ifdef TRAP_VECTORED_MTVEC_EN
  input  logic [XLEN-1:0] cause_i,
`endif
  output logic [XLEN-1:0] target_o
);

  // Masking (rather than slicing) keeps every mtvec bit consumed in direct mode.
  localparam logic [XLEN-1:0] BASE_MASK = ~(XLEN'(3));

  logic [XLEN-1:0] base;

  always_comb begin
    base     = mtvec_i & BASE_MASK;
    target_o = base;
`ifdef TRAP_VECTORED_MTVEC_EN
    // Interrupt bit is cause MSB; shifting by 2 drops the top two bits,
    // which is exactly 4*cause[XLEN-2:0] truncated to XLEN.
    if (cause_i[XLEN-1] && (mtvec_i[1:0] == MTVEC_VECTORED))
      target_o = base + (cause_i << 2);
`endif
    if (sel_mepc_i)
      target_o = mepc_i;
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences trap entry (ecall / timer interrupt) and mret return
// around the machine-mode CSR file, flushing the front end and redirecting
// the IFU through a valid/ready handshake.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i / ready_o     retiring-instruction event handshake (ready in IDLE)
//   pc_i, is_ecall_i, is_mret_i   retiring instruction info
//   irq_timer_i, mie_i    level timer interrupt and mstatus.MIE
//   mtvec_i, mepc_i       current CSR values
//   csr_ecall_o, mepc_o, mcause_o   trap-entry strobe and CSR write data
//   csr_mret_o            mret strobe (restore MIE)
//   flush_o               kill younger instructions
//   redirect_valid_o / redirect_ready_i / redirect_pc_o   IFU redirect
// Macro TRAP_VECTORED_MTVEC_EN enables vectored interrupt targets.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] CAUSE_ECALL_M = XLEN'(DEF_CAUSE_ECALL_M),
  parameter logic [XLEN-1:0] CAUSE_MTIMER  = XLEN'(DEF_CAUSE_MTIMER)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic            is_ecall_i,
  input  logic            is_mret_i,
  input  logic            irq_timer_i,
  input  logic            mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            csr_ecall_o,
  output logic            csr_mret_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [XLEN-1:0] redirect_pc_o
);

  state_e          state_q;
  logic            ready_q, flush_q, rvalid_q, ecall_q, mret_q;
  logic [XLEN-1:0] pc_q, cause_q;
  logic [XLEN-1:0] target;
  logic            take_irq;

  // Interrupt outranks the retiring instruction, whose flags are then ignored.
  assign take_irq = irq_timer_i & mie_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      flush_q  <= 1'b0;
      rvalid_q <= 1'b0;
      ecall_q  <= 1'b0;
      mret_q   <= 1'b0;
      pc_q     <= '0;
      cause_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            if (take_irq || is_ecall_i) begin
              pc_q    <= pc_i;
              cause_q <= take_irq ? CAUSE_MTIMER : CAUSE_ECALL_M;
              state_q <= ST_SAVE;
              ready_q <= 1'b0;
              flush_q <= 1'b1;
              ecall_q <= 1'b1;
            end else if (is_mret_i) begin
              // mret redirects in the same cycle as its strobe.
              state_q  <= ST_RET;
              ready_q  <= 1'b0;
              flush_q  <= 1'b1;
              rvalid_q <= 1'b1;
              mret_q   <= 1'b1;
            end
          end
        end
        ST_SAVE: begin
          ecall_q  <= 1'b0;
          rvalid_q <= 1'b1;
          state_q  <= ST_JUMP;
        end
        ST_JUMP, ST_RET: begin
          // Strobe only on the first RET cycle, even if the IFU stalls.
          mret_q <= 1'b0;
          if (redirect_ready_i) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            flush_q  <= 1'b0;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Target is read from live CSRs in JUMP/RET, i.e. after the SAVE write.
  trap_target_calc #(.XLEN(XLEN)) u_target (
    .sel_mepc_i (state_q == ST_RET),
    .mtvec_i    (mtvec_i),
    .mepc_i     (mepc_i),
`ifdef TRAP_VECTORED_MTVEC_EN
    .cause_i    (cause_q),
`endif
    .target_o   (target)
  );

  assign ready_o          = ready_q;
  assign flush_o          = flush_q;
  assign csr_ecall_o      = ecall_q;
  assign csr_mret_o       = mret_q;
  assign redirect_valid_o = rvalid_q;
  assign redirect_pc_o    = rvalid_q ? target : '0;
  assign mepc_o           = ecall_q ? pc_q : '0;
  assign mcause_o         = ecall_q ? cause_q : '0;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  localparam int K_ECALL = 0;
  localparam int K_MRET  = 1;
  localparam int K_REDIR = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] pc_i;
  logic        is_ecall_i, is_mret_i, irq_timer_i, mie_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        csr_ecall_o, csr_mret_o;
  logic [31:0] mepc_o, mcause_o;
  logic        flush_o, redirect_valid_o, redirect_ready_i;
  logic [31:0] redirect_pc_o;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        mon_en  = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_pc = '0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .pc_i             (pc_i),
    .is_ecall_i       (is_ecall_i),
    .is_mret_i        (is_mret_i),
    .irq_timer_i      (irq_timer_i),
    .mie_i            (mie_i),
    .mtvec_i          (mtvec_i),
    .mepc_i           (mepc_i),
    .csr_ecall_o      (csr_ecall_o),
    .csr_mret_o       (csr_mret_o),
    .mepc_o           (mepc_o),
    .mcause_o         (mcause_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_ready_i (redirect_ready_i),
    .redirect_pc_o    (redirect_pc_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int kind, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_event", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", 32'(kind), 32'(e.kind));
      if (kind == K_ECALL) begin
        chk("sb_mepc", a, e.a);
        chk("sb_mcause", b, e.b);
      end else if (kind == K_REDIR) begin
        chk("sb_redirect_pc", a, e.a);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or a redirect handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      if (csr_ecall_o) pop_check(K_ECALL, mepc_o, mcause_o);
      else             chk("csr_data_zero", mepc_o | mcause_o, 32'h0);
      if (csr_mret_o) pop_check(K_MRET, 32'h0, 32'h0);
      if (redirect_valid_o && redirect_ready_i) pop_check(K_REDIR, redirect_pc_o, 32'h0);
      if (redirect_valid_o && stall_prev) chk("redirect_stable", redirect_pc_o, stall_pc);
      stall_prev = redirect_valid_o && !redirect_ready_i;
      stall_pc   = redirect_pc_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Present one retiring instruction for exactly one cycle (accepted at the edge).
  task automatic issue(input logic [31:0] pc, input logic ec, input logic mr,
                       input logic irq, input logic mie);
    @(posedge clk); #1;
    valid_i = 1'b1; pc_i = pc; is_ecall_i = ec; is_mret_i = mr;
    irq_timer_i = irq; mie_i = mie;
    @(posedge clk); #1;
    valid_i = 1'b0; is_ecall_i = 1'b0; is_mret_i = 1'b0; irq_timer_i = 1'b0;
  endtask

  // Trap entry with the IFU always ready: strobe at +1, redirect at +2, IDLE at +3.
  task automatic trap_case(input string name, input logic [31:0] pc, input logic [31:0] mtvec,
                           input logic ec, input logic mr, input logic irq, input logic mie,
                           input logic [31:0] exp_cause, input logic [31:0] exp_pc);
    mtvec_i = mtvec;
    redirect_ready_i = 1'b1;
    push(K_ECALL, pc, exp_cause);
    push(K_REDIR, exp_pc, 32'h0);
    issue(pc, ec, mr, irq, mie);
    @(negedge clk);
    chk({name, "_strobe_p1"}, {31'h0, csr_ecall_o}, 32'h1);
    chk({name, "_flush_p1"}, {31'h0, flush_o}, 32'h1);
    chk({name, "_no_redir_p1"}, {31'h0, redirect_valid_o}, 32'h0);
    @(negedge clk);
    chk({name, "_redir_p2"}, {31'h0, redirect_valid_o}, 32'h1);
    @(negedge clk);
    chk({name, "_idle_p3"}, {31'h0, ready_o}, 32'h1);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; pc_i = '0; is_ecall_i = 1'b0; is_mret_i = 1'b0;
    irq_timer_i = 1'b0; mie_i = 1'b0; mtvec_i = 32'h8000_0100; mepc_i = '0;
    redirect_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'h0, ready_o}, 32'h1);
    chk("reset_ctrl", {28'h0, csr_ecall_o, csr_mret_o, flush_o, redirect_valid_o}, 32'h0);
    chk("reset_data", mepc_o | mcause_o | redirect_pc_o, 32'h0);
    mon_en = 1'b1;

    // Plain ecall, direct mtvec.
    trap_case("ecall", 32'h8000_0010, 32'h8000_0100, 1, 0, 0, 0, 32'd11, 32'h8000_0100);

    // mret with IFU stalled for 3 cycles; a timer irq shows up meanwhile and
    // must wait until IDLE, then be taken.
    mepc_i = 32'h8000_0014;
    redirect_ready_i = 1'b0;
    push(K_MRET, 32'h0, 32'h0);
    push(K_REDIR, 32'h8000_0014, 32'h0);
    push(K_ECALL, 32'h8000_0030, 32'h8000_0007);
    push(K_REDIR, 32'h8000_0100, 32'h0);
    issue(32'h8000_0040, 0, 1, 0, 0);
    valid_i = 1'b1; pc_i = 32'h8000_0030; irq_timer_i = 1'b1; mie_i = 1'b1;
    @(negedge clk);
    chk("mret_strobe_p1", {31'h0, csr_mret_o}, 32'h1);
    chk("mret_redir_p1", {31'h0, redirect_valid_o}, 32'h1);
    chk("mret_pc_p1", redirect_pc_o, 32'h8000_0014);
    repeat (2) begin
      @(negedge clk);
      chk("mret_no_repeat", {31'h0, csr_mret_o}, 32'h0);
      chk("busy_not_ready", {31'h0, ready_o}, 32'h0);
    end
    @(posedge clk); #1 redirect_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mret_idle", {31'h0, ready_o}, 32'h1);
    @(posedge clk); #1;
    valid_i = 1'b0; irq_timer_i = 1'b0; mie_i = 1'b0;
    repeat (4) @(posedge clk);

    // Interrupt outranks a retiring ecall.
    trap_case("irq_mie1", 32'h8000_0020, 32'h8000_0100, 1, 0, 1, 1, 32'h8000_0007, 32'h8000_0100);
    // Masked interrupt: ecall handled.
    trap_case("irq_mie0", 32'h8000_0024, 32'h8000_0100, 1, 0, 1, 0, 32'd11, 32'h8000_0100);
    // Illegal ecall+mret decode: ecall wins.
    trap_case("ecall_mret", 32'h8000_0028, 32'h8000_0100, 1, 1, 0, 0, 32'd11, 32'h8000_0100);
    // Vectored mtvec mode.
`ifdef TRAP_VECTORED_MTVEC_EN
    trap_case("vec_irq", 32'h8000_0050, 32'h8000_0101, 0, 0, 1, 1, 32'h8000_0007, 32'h8000_011C);
`else
    trap_case("vec_irq", 32'h8000_0050, 32'h8000_0101, 0, 0, 1, 1, 32'h8000_0007, 32'h8000_0100);
`endif
    trap_case("vec_ecall", 32'h8000_0054, 32'h8000_0101, 1, 0, 0, 0, 32'd11, 32'h8000_0100);

    // Reset while in JUMP with the IFU stalled: no redirect ever handshakes.
    mtvec_i = 32'h8000_0100;
    redirect_ready_i = 1'b0;
    push(K_ECALL, 32'h8000_0060, 32'd11);
    issue(32'h8000_0060, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("jump_before_rst", {31'h0, redirect_valid_o}, 32'h1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, ready_o}, 32'h1);
    chk("rst_outputs", {28'h0, csr_ecall_o, csr_mret_o, flush_o, redirect_valid_o}, 32'h0);
    chk("rst_pc", redirect_pc_o, 32'h0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_still_idle", {30'h0, ready_o, flush_o}, 32'h2);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
